fire_bias_relu: RTL and testbench
=================================

# fire_bias_relu

Post-accumulation output stage for a fire-module conv layer (expand1/expand3/squeeze). It takes one signed accumulator result per output channel, in channel order. For each result it adds that channel's sign-magnitude bias from the layer's bias ROM, rescales, saturates and applies ReLU. It emits one 16-bit sign-magnitude activation per channel over a 2-stage valid/ready pipeline.

## Interface
- NUM_CH, 128: output channels per pixel; size of bias_mem.
- ACC_W, 32: accumulator width, two's complement.
- BIAS_SHIFT, 8: left shift aligning the bias to the accumulator scale.
- OUT_SHIFT, 8: arithmetic right shift from the accumulator scale to the output scale.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- bias_mem  in  [15:0] x NUM_CH  bias ROM contents; sign-magnitude (bit15 sign, [14:0] magnitude).
- clear  in  1  synchronous; forces the channel counter to 0 (frame/pixel start).
- in_valid  in  1  in_data valid.
- in_ready  out  1  stage accepts in_data this cycle.
- in_data  in  ACC_W  accumulator result for the current channel.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  16  activation, sign-magnitude.
- out_ch  out  $clog2(NUM_CH)  channel index of out_data.
- out_last  out  1  out_ch == NUM_CH-1.

## Operation
- Channel counter ch: increments on each accepted input (in_valid && in_ready) and wraps NUM_CH-1 -> 0.
  - clear sets ch to 0.
  - If clear and an accept occur in the same cycle, the accepted beat uses the old ch and the counter becomes 0.
- Bias conversion: b = bit15 ? -mag : +mag. 0x8000 (negative zero) becomes 0.
- Stage 1: sum = sext(in_data) + (b <<< BIAS_SHIFT), computed at ACC_W+1 bits with no overflow. Registers sum and ch.
- Stage 2: r = sum >>> OUT_SHIFT (floor). ReLU: r<0 -> 0. Saturate |r| to 32767.
  - Encode as sign-magnitude; zero is always 0x0000.
  - Registers out_data, out_ch and out_last.
- Flow control: en = !out_valid || out_ready. in_ready = en; this is a combinational path from out_ready.
  - When en is high, both stages advance and bubbles propagate.
  - When en is low, all pipeline registers hold.
- Reset: ch=0, stage valids=0, out_valid=0, out_data=0x0000, out_ch=0, out_last=0.
  - Reset mid-operation discards in-flight beats; nothing is replayed.

## Timing
- Latency: an input accepted in cycle N appears on out_valid/out_data in cycle N+2 when out_ready stays high.
- Throughput: 1 beat/cycle with no stalls.
- While out_valid && !out_ready: out_data, out_ch and out_last are stable, and in_ready=0.
- bias_mem is sampled in the accept cycle.

## Configuration
- FIRE_BIAS_RELU_EN defined: ReLU applied as above; out_data[15] is always 0.
- FIRE_BIAS_RELU_EN undefined: no ReLU. Negative r is saturated to -32767 and output with sign=1 (e.g. 0xFFFF); used for the final classifier layer.

## Test plan
- Positive path. Reset, then stream 128 beats with out_ready=1; beat 0 is in_data=4096 with bias_mem[0]=0x0005.
  - Required: out_data=0x0015 two cycles after accept; out_ch=0.
  - Required: out_last=1 only on beat 127; the counter wraps to 0 on beat 128.
- Negative and zero bias.
  - in_data=-2560 with bias 0x802E -> 0x0000 with ReLU, 0x8038 without.
  - Bias 0x8000 with in_data=512 -> 0x0002.
- Saturation.
  - in_data=0x7FFFFFFF with bias 0x00E6 -> 0x7FFF.
  - Without ReLU: in_data=0x80000000 with bias 0x80EB -> 0xFFFF.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream.
  - Required: in_ready=0 while out_valid=1, and outputs are stable.
  - Required: no beats are lost or duplicated, and the channel order is intact.
- clear: assert clear together with the accept of channel 37.
  - Required: that beat reports out_ch=37 and the next accepted beat reports out_ch=0.
- Async reset: assert rst_n=0 with both stages full.
  - Required: out_valid=0 and out_data=0x0000 immediately, not waiting for clk.
  - Required: the first beat after release has out_ch=0.

Source files
------------

// File: rtl/fire_bias_relu.sv
// Bias-add, rescale, saturate and optional ReLU output stage for fire-module conv layers.
// Two-stage valid/ready pipeline; define FIRE_BIAS_RELU_EN to clamp negative results to zero.
module fire_bias_relu #(
  parameter int unsigned NUM_CH     = 128,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned BIAS_SHIFT = 8,
  parameter int unsigned OUT_SHIFT  = 8,
  localparam int unsigned CH_W      = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0][15:0]  i_bias_mem,
  input  logic                     i_clear,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [ACC_W-1:0]         i_in_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [15:0]              o_out_data,
  output logic [CH_W-1:0]          o_out_ch,
  output logic                     o_out_last
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] MaxMag = SUM_W'(32767);
  localparam logic [CH_W-1:0] LastCh = CH_W'(NUM_CH - 1);

  logic [CH_W-1:0]         r_ch, r_s1_ch, r_out_ch;
  logic                    r_s1_valid, r_out_valid, r_out_last;
  logic signed [SUM_W-1:0] r_s1_sum;
  logic [15:0]             r_out_data;

  logic                    w_en, w_accept;
  logic [15:0]             w_bias_raw;
  logic signed [SUM_W-1:0] w_bias_ext, w_sum, w_r;
  logic [15:0]             w_act;

  assign w_en       = !r_out_valid || i_out_ready;
  assign w_accept   = i_in_valid && w_en;
  assign w_bias_raw = i_bias_mem[r_ch];

  // Sign-magnitude to two's complement; negative zero falls out as 0.
  always_comb begin
    w_bias_ext       = '0;
    w_bias_ext[14:0] = w_bias_raw[14:0];
    if (w_bias_raw[15]) w_bias_ext = -w_bias_ext;
  end

  assign w_sum = $signed({i_in_data[ACC_W-1], i_in_data}) + (w_bias_ext <<< BIAS_SHIFT);
  assign w_r   = r_s1_sum >>> OUT_SHIFT;

`ifndef FIRE_BIAS_RELU_EN
  logic signed [SUM_W-1:0] w_r_neg;
  assign w_r_neg = -w_r;
`endif

  always_comb begin
    w_act = 16'h0000;
    if (w_r > MaxMag) begin
      w_act = 16'h7FFF;
    end else if (!w_r[SUM_W-1]) begin
      w_act = {1'b0, w_r[14:0]};
    end else begin
`ifdef FIRE_BIAS_RELU_EN
      w_act = 16'h0000;
`else
      if (w_r_neg > MaxMag) w_act = 16'hFFFF;
      else                  w_act = {1'b1, w_r_neg[14:0]};
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch        <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_sum    <= '0;
      r_s1_ch     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= 16'h0000;
      r_out_ch    <= '0;
      r_out_last  <= 1'b0;
    end else begin
      // clear wins over increment, but the accepted beat keeps the old channel.
      if (i_clear)       r_ch <= '0;
      else if (w_accept) r_ch <= (r_ch == LastCh) ? '0 : r_ch + 1'b1;
      if (w_en) begin
        r_s1_valid  <= i_in_valid;
        r_out_valid <= r_s1_valid;
        if (w_accept) begin
          r_s1_sum <= w_sum;
          r_s1_ch  <= r_ch;
        end
        if (r_s1_valid) begin
          r_out_data <= w_act;
          r_out_ch   <= r_s1_ch;
          r_out_last <= (r_s1_ch == LastCh);
        end
      end
    end
  end

  assign o_in_ready  = w_en;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_ch    = r_out_ch;
  assign o_out_last  = r_out_last;

endmodule

// File: tb/tb_fire_bias_relu.sv
// Randomized bench for fire_bias_relu: queue-based reference model plus directed literal checks.
module tb_fire_bias_relu;
  localparam int unsigned NUM_CH = 128;
  localparam int unsigned CH_W   = 7;

  typedef struct packed {
    logic [15:0]     d;
    logic [CH_W-1:0] ch;
    logic            last;
  } exp_t;

  logic                    clk, rst_n;
  logic [NUM_CH-1:0][15:0] bias_mem;
  logic                    i_clear, i_in_valid, o_in_ready;
  logic [31:0]             i_in_data;
  logic                    o_out_valid, i_out_ready;
  logic [15:0]             o_out_data;
  logic [CH_W-1:0]         o_out_ch;
  logic                    o_out_last;

  fire_bias_relu #(.NUM_CH(NUM_CH), .ACC_W(32), .BIAS_SHIFT(8), .OUT_SHIFT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_bias_mem (bias_mem),
    .i_clear    (i_clear),
    .i_in_valid (i_in_valid),
    .o_in_ready (o_in_ready),
    .i_in_data  (i_in_data),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
    .o_out_data (o_out_data),
    .o_out_ch   (o_out_ch),
    .o_out_last (o_out_last)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  int   mch = 0;
  logic prev_stall = 1'b0;
  exp_t prev_o;

`ifdef FIRE_BIAS_RELU_EN
  localparam bit Relu = 1'b1;
`else
  localparam bit Relu = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the decoded values.
  function automatic logic [15:0] model(input logic [31:0] d, input logic [15:0] b);
    longint bv, s, r;
    logic [15:0] mag;
    bv = b[15] ? -longint'(b[14:0]) : longint'(b[14:0]);
    s  = longint'($signed(d)) + bv * 256;
    r  = s >>> 8;
    if (r > 32767) return 16'h7FFF;
    if (r >= 0) return {1'b0, 15'(r)};
    if (Relu) return 16'h0000;
    mag = (r < -32767) ? 16'd32767 : 16'(-r);
    return {1'b1, mag[14:0]};
  endfunction

  function automatic logic [31:0] rand_data();
    case ($urandom % 4)
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 2 ** 21)) - 32'd1048576;
      2:       return 32'h7FFF_FF00 + 32'($urandom % 256);
      default: return 32'h8000_0000 + 32'($urandom % 256);
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, o_out_valid}, 32'd1);
        chk("stall_data", {16'd0, o_out_data}, {16'd0, prev_o.d});
        chk("stall_ch", {25'd0, o_out_ch}, {25'd0, prev_o.ch});
        chk("stall_last", {31'd0, o_out_last}, {31'd0, prev_o.last});
      end
      if (o_out_valid && !i_out_ready) chk("stall_in_ready", {31'd0, o_in_ready}, 32'd0);
      if (o_out_valid && i_out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("out_data", {16'd0, o_out_data}, {16'd0, e.d});
          chk("out_ch", {25'd0, o_out_ch}, {25'd0, e.ch});
          chk("out_last", {31'd0, o_out_last}, {31'd0, e.last});
        end
      end
      if (i_in_valid && o_in_ready) begin
        e.d    = model(i_in_data, bias_mem[mch]);
        e.ch   = CH_W'(mch);
        e.last = (mch == NUM_CH - 1);
        q.push_back(e);
        mch = i_clear ? 0 : (mch + 1) % NUM_CH;
      end else if (i_clear) begin
        mch = 0;
      end
      prev_stall = o_out_valid && !i_out_ready;
      prev_o     = '{d: o_out_data, ch: o_out_ch, last: o_out_last};
    end
  end

  task automatic drain();
    int k = 0;
    i_in_valid  = 1'b0;
    i_clear     = 1'b0;
    i_out_ready = 1'b1;
    while (q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic stream_n(input int n);
    i_out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      i_in_valid = 1'b1;
      i_in_data  = rand_data();
      @(posedge clk);
      #1;
    end
    i_in_valid = 1'b0;
  endtask

  // One isolated beat; the result must appear two cycles after the accept.
  task automatic beat_check(input string name, input logic [31:0] d, input logic [15:0] b,
                            input logic clr, input logic [15:0] exp_d, input int exp_ch);
    drain();
    bias_mem[mch] = b;
    i_in_data  = d;
    i_in_valid = 1'b1;
    i_clear    = clr;
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    i_clear    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({name, "_valid"}, {31'd0, o_out_valid}, 32'd1);
    chk({name, "_data"}, {16'd0, o_out_data}, {16'd0, exp_d});
    chk({name, "_ch"}, {25'd0, o_out_ch}, 32'(exp_ch));
    chk({name, "_last"}, {31'd0, o_out_last}, {31'd0, exp_ch == NUM_CH - 1});
  endtask

  initial begin
    logic [31:0] d;
    logic [15:0] b;
    clk = 1'b0;
    rst_n = 1'b0;
    i_clear = 1'b0;
    i_in_valid = 1'b0;
    i_in_data = '0;
    i_out_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) bias_mem[i] = 16'($urandom);
    #12;
    chk("rst_valid", {31'd0, o_out_valid}, 32'd0);
    chk("rst_data", {16'd0, o_out_data}, 32'd0);
    chk("rst_ch", {25'd0, o_out_ch}, 32'd0);
    chk("rst_last", {31'd0, o_out_last}, 32'd0);
    chk("rst_in_ready", {31'd0, o_in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Positive path, last flag and wrap.
    beat_check("pos_beat0", 32'd4096, 16'h0005, 1'b0, 16'h0015, 0);
    drain();
    stream_n(126);
    d = rand_data(); b = 16'($urandom);
    beat_check("beat127", d, b, 1'b0, model(d, b), 127);
    d = rand_data(); b = 16'($urandom);
    beat_check("wrap", d, b, 1'b0, model(d, b), 0);

    // Negative, zero-bias and saturation corners.
    beat_check("neg_bias", 32'hFFFF_F600, 16'h802E, 1'b0, Relu ? 16'h0000 : 16'h8038, 1);
    beat_check("neg_zero", 32'd512, 16'h8000, 1'b0, 16'h0002, 2);
    beat_check("sat_pos", 32'h7FFF_FFFF, 16'h00E6, 1'b0, 16'h7FFF, 3);
    beat_check("sat_neg", 32'h8000_0000, 16'h80EB, 1'b0, Relu ? 16'h0000 : 16'hFFFF, 4);

    // Backpressure mid-stream.
    drain();
    stream_n(10);
    i_in_valid = 1'b1;
    i_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i_in_data = rand_data();
      @(negedge clk);
      chk("bp_in_ready", {31'd0, o_in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    stream_n(10);
    drain();

    // clear coincident with the accept of channel 37.
    stream_n((37 - mch + NUM_CH) % NUM_CH);
    d = rand_data(); b = 16'($urandom);
    beat_check("clr37", d, b, 1'b1, model(d, b), 37);
    d = rand_data(); b = 16'($urandom);
    beat_check("after_clr", d, b, 1'b0, model(d, b), 0);

    // Randomized traffic with random stalls, clears and bias updates.
    drain();
    for (int i = 0; i < 3000; i++) begin
      i_in_valid  = ($urandom % 4) != 0;
      i_in_data   = rand_data();
      i_out_ready = ($urandom % 3) != 0;
      i_clear     = ($urandom % 64) == 0;
      bias_mem[$urandom % NUM_CH] = 16'($urandom);
      @(posedge clk);
      #1;
    end
    drain();

    // Asynchronous reset with both stages full.
    i_out_ready = 1'b0;
    i_in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_in_data = rand_data();
      @(posedge clk);
      #1;
    end
    chk("full_before_rst", {31'd0, o_out_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, o_out_valid}, 32'd0);
    chk("arst_data", {16'd0, o_out_data}, 32'd0);
    i_in_valid = 1'b0;
    q.delete();
    mch = 0;
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    d = rand_data(); b = 16'($urandom);
    beat_check("post_rst", d, b, 1'b0, model(d, b), 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
